// File: rtl/cache_pkg.sv
// cache_pkg: controller state encoding, default cache geometry and the
// tag-width helper shared by the interface, the data array and the controller.
package cache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        COMPARE,
        MEMRD,
        FILL,
        MEMWR,
        RESP
    } state_t;

    localparam int DEF_INDEX      = 3;
    localparam int DEF_CACHESIZE  = 8;
    localparam int DEF_MEMORYBITS = 5;
    localparam int DEF_DATAWIDTH  = 8;

    // Tag bits are whatever address bits the index does not consume.
    function automatic int tag_width(input int memorybits, input int index);
        return memorybits - index;
    endfunction

endpackage

// File: rtl/cache_if.sv
// cache_if: CPU load/store port, tag store port and memory port of the cache
// controller. The master modport is the controller's view; slave is the
// surrounding system (CPU, tag RAM, memory).
interface cache_if
    import cache_pkg::*;
#(
    parameter int INDEX      = DEF_INDEX,
    parameter int MEMORYBITS = DEF_MEMORYBITS,
    parameter int DATAWIDTH  = DEF_DATAWIDTH
) ();

    localparam int TW = tag_width(MEMORYBITS, INDEX);

    // CPU side
    logic                  cpu_req;
    logic                  cpu_we;
    logic [MEMORYBITS-1:0] cpu_addr;
    logic [DATAWIDTH-1:0]  cpu_wdata;
    logic                  cpu_ready;
    logic                  cpu_rvalid;
    logic [DATAWIDTH-1:0]  cpu_rdata;
    logic                  cpu_hit;

    // Tag store side
    logic [INDEX-1:0]      tag_index;
    logic                  tag_read;
    logic                  tag_write;
    logic [TW-1:0]         tag_wdata;
    logic [TW-1:0]         tag_rdata;

    // Memory side
    logic                  mem_req;
    logic                  mem_we;
    logic [MEMORYBITS-1:0] mem_addr;
    logic [DATAWIDTH-1:0]  mem_wdata;
    logic                  mem_ack;
    logic [DATAWIDTH-1:0]  mem_rdata;

    modport master (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ready, cpu_rvalid, cpu_rdata, cpu_hit,
        output tag_index, tag_read, tag_write, tag_wdata,
        input  tag_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ready, cpu_rvalid, cpu_rdata, cpu_hit,
        input  tag_index, tag_read, tag_write, tag_wdata,
        output tag_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );

endinterface

// File: rtl/cache_data_array.sv
// cache_data_array: CACHESIZE x DATAWIDTH line storage plus one valid bit per
// line. Single index shared by the read and write paths; reads are
// combinational, writes synchronous. Only the valid bits are reset.
module cache_data_array
    import cache_pkg::*;
#(
    parameter int INDEX     = DEF_INDEX,
    parameter int CACHESIZE = DEF_CACHESIZE,
    parameter int DATAWIDTH = DEF_DATAWIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [INDEX-1:0]     idx,
    input  logic                 wr_en,
    input  logic                 set_valid,
    input  logic [DATAWIDTH-1:0] wr_data,
    output logic [DATAWIDTH-1:0] rd_data,
    output logic                 rd_valid
);

    logic [DATAWIDTH-1:0] data_mem [CACHESIZE];
    logic [CACHESIZE-1:0] valid_q;

    // Line data: written on a store hit or a refill, contents survive reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_mem[idx] <= wr_data;
        end
    end

    // Valid bits: cleared asynchronously, set only by a refill
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (wr_en && set_valid) begin
            valid_q[idx] <= 1'b1;
        end
    end

    assign rd_data  = data_mem[idx];
    assign rd_valid = valid_q[idx];

endmodule

// File: rtl/cache_ctrl.sv
// cache_ctrl: direct-mapped, write-through, no-write-allocate cache controller.
// Drives an external tag store, keeps data and valid bits in cache_data_array,
// refills from memory over a req/ack handshake on a load miss.
// Optional build macro CACHE_STATS_EN adds saturating load hit/miss counters.
module cache_ctrl
    import cache_pkg::*;
#(
    parameter int INDEX      = DEF_INDEX,
    parameter int CACHESIZE  = DEF_CACHESIZE,
    parameter int MEMORYBITS = DEF_MEMORYBITS,
    parameter int DATAWIDTH  = DEF_DATAWIDTH
) (
    input  logic        clk,
    input  logic        rst_n,
    cache_if.master     bus
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
`endif
);

    localparam int TW = tag_width(MEMORYBITS, INDEX);

    state_t                state_q;
    state_t                state_d;

    // Request captured in IDLE; not reset, only meaningful after acceptance
    logic [MEMORYBITS-1:0] addr_q;
    logic                  we_q;
    logic [DATAWIDTH-1:0]  wdata_q;
    logic [DATAWIDTH-1:0]  fill_q;
    logic                  hit_q;

    logic [INDEX-1:0]      idx;
    logic [TW-1:0]         tag;
    logic                  hit;

    logic [DATAWIDTH-1:0]  line_data;
    logic                  line_valid;
    logic                  arr_we;
    logic                  arr_set_valid;
    logic [DATAWIDTH-1:0]  arr_wdata;

    assign idx = addr_q[INDEX-1:0];
    assign tag = addr_q[MEMORYBITS-1:INDEX];
    // tag_rdata is only meaningful in COMPARE, one cycle after the LOOKUP read
    assign hit = line_valid && (bus.tag_rdata == tag);

    cache_data_array #(
        .INDEX     (INDEX),
        .CACHESIZE (CACHESIZE),
        .DATAWIDTH (DATAWIDTH)
    ) u_data_array (
        .clk       (clk),
        .rst_n     (rst_n),
        .idx       (idx),
        .wr_en     (arr_we),
        .set_valid (arr_set_valid),
        .wr_data   (arr_wdata),
        .rd_data   (line_data),
        .rd_valid  (line_valid)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and decoded outputs; all strobes default low so reset drops them at once
    always_comb begin
        state_d        = state_q;
        bus.cpu_ready  = 1'b0;
        bus.tag_index  = '0;
        bus.tag_read   = 1'b0;
        bus.tag_write  = 1'b0;
        bus.tag_wdata  = '0;
        bus.mem_req    = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        arr_we         = 1'b0;
        arr_set_valid  = 1'b0;
        arr_wdata      = wdata_q;

        case (state_q)
            IDLE: begin
                bus.cpu_ready = 1'b1;
                if (bus.cpu_req) begin
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                bus.tag_read  = 1'b1;
                bus.tag_index = idx;
                state_d       = COMPARE;
            end
            COMPARE: begin
                if (we_q) begin
                    // Store hit refreshes the line; a store miss never allocates
                    arr_we  = hit;
                    state_d = MEMWR;
                end else if (hit) begin
                    state_d = RESP;
                end else begin
                    state_d = MEMRD;
                end
            end
            MEMRD: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = addr_q;
                if (bus.mem_ack) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                bus.tag_write = 1'b1;
                bus.tag_wdata = tag;
                bus.tag_index = idx;
                arr_we        = 1'b1;
                arr_set_valid = 1'b1;
                arr_wdata     = fill_q;
                state_d       = RESP;
            end
            MEMWR: begin
                bus.mem_req   = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_addr  = addr_q;
                bus.mem_wdata = wdata_q;
                if (bus.mem_ack) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Capture the accepted request and the refill word
    always_ff @(posedge clk) begin
        if (state_q == IDLE && bus.cpu_req) begin
            addr_q  <= bus.cpu_addr;
            we_q    <= bus.cpu_we;
            wdata_q <= bus.cpu_wdata;
        end
        if (state_q == MEMRD && bus.mem_ack) begin
            fill_q <= bus.mem_rdata;
        end
    end

    // Registered CPU response, non-zero only while in RESP; hit_q carries the store compare result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.cpu_rvalid <= 1'b0;
            bus.cpu_rdata  <= '0;
            bus.cpu_hit    <= 1'b0;
            hit_q          <= 1'b0;
        end else begin
            bus.cpu_rvalid <= (state_d == RESP);
            if (state_q == COMPARE) begin
                hit_q <= hit;
            end
            if (state_d == RESP) begin
                bus.cpu_hit   <= (state_q == COMPARE) ? hit : hit_q;
                bus.cpu_rdata <= (state_q == COMPARE) ? line_data :
                                 (state_q == FILL)    ? fill_q    : '0;
            end else begin
                bus.cpu_hit   <= 1'b0;
                bus.cpu_rdata <= '0;
            end
        end
    end

`ifdef CACHE_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Load-only hit/miss statistics, counted at the tag compare
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state_q == COMPARE && !we_q) begin
            if (hit) begin
                hit_count <= sat_inc(hit_count);
            end else begin
                miss_count <= sat_inc(miss_count);
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: directed and randomized load/store sequence against a
// transaction-level cache model; the bench also plays tag RAM and memory.
`timescale 1ns/1ps
module tb_cache_ctrl;

    localparam int INDEX      = 3;
    localparam int MEMORYBITS = 5;
    localparam int DATAWIDTH  = 8;
    localparam int TW         = MEMORYBITS - INDEX;
    localparam int LINES      = 1 << INDEX;
    localparam int WORDS      = 1 << MEMORYBITS;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cache_if bus ();

`ifdef CACHE_STATS_EN
    logic [15:0] hit_count;
    logic [15:0] miss_count;
`endif

    cache_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus)
`ifdef CACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    int errors = 0;
    int checks = 0;

    // Reference cache contents and reference memory
    bit                   m_valid [LINES];
    logic [TW-1:0]        m_tag   [LINES];
    logic [DATAWIDTH-1:0] m_data  [LINES];
    logic [DATAWIDTH-1:0] ref_mem [WORDS];
    int                   m_hits   = 0;
    int                   m_misses = 0;

    // Environment: external tag RAM and main memory as the DUT sees them
    logic [TW-1:0]        tag_ram  [LINES];
    logic [DATAWIDTH-1:0] phys_mem [WORDS];

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // One CPU transaction issued at a negedge while the controller is idle.
    task automatic do_op(input bit we, input logic [MEMORYBITS-1:0] addr,
                         input logic [DATAWIDTH-1:0] wdata);
        logic [INDEX-1:0]     i;
        logic [TW-1:0]        t;
        bit                   exp_hit;
        logic [DATAWIDTH-1:0] exp_rdata;
        int                   k;
        int                   ack_k;
        int                   delay;
        int                   seen;
        int                   lat;
        bit                   got;
        bit                   memseen;

        i         = addr[INDEX-1:0];
        t         = addr[MEMORYBITS-1:INDEX];
        exp_hit   = m_valid[i] && (m_tag[i] == t);
        exp_rdata = exp_hit ? m_data[i] : ref_mem[addr];

        chk("ready_before_req", 32'(bus.cpu_ready), 32'd1);
        bus.tag_rdata = TW'($urandom);
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wdata;
        @(posedge clk);
        @(negedge clk);
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'($urandom);
        bus.cpu_addr  = MEMORYBITS'($urandom);
        bus.cpu_wdata = DATAWIDTH'($urandom);

        k       = 1;
        ack_k   = -100;
        got     = 1'b0;
        memseen = 1'b0;
        seen    = 0;
        delay   = int'($urandom_range(0, 3));
        while (!got && k < 60) begin
            chk("tag_rd_wr_excl", 32'(bus.tag_read & bus.tag_write), 32'd0);
            if (k == 1) begin
                chk("lookup_read", 32'(bus.tag_read), 32'd1);
                chk("lookup_index", 32'(bus.tag_index), 32'(i));
            end
            if (bus.tag_read) bus.tag_rdata = tag_ram[bus.tag_index];
            if (bus.tag_write) tag_ram[bus.tag_index] = bus.tag_wdata;
            if (k == ack_k + 1) begin
                chk("mem_req_drop", 32'(bus.mem_req), 32'd0);
                if (!we) begin
                    chk("fill_tag_write", 32'(bus.tag_write), 32'd1);
                    chk("fill_tag_wdata", 32'(bus.tag_wdata), 32'(t));
                    chk("fill_tag_index", 32'(bus.tag_index), 32'(i));
                end
            end
            if (bus.cpu_rvalid) begin
                got = 1'b1;
                lat = we ? ack_k + 1 : (exp_hit ? 3 : ack_k + 2);
                chk("resp_latency", 32'(k), 32'(lat));
                chk("resp_hit", 32'(bus.cpu_hit), 32'(exp_hit));
                if (!we) chk("resp_rdata", 32'(bus.cpu_rdata), 32'(exp_rdata));
                chk("mem_access", 32'(memseen), 32'(we || !exp_hit));
            end else if (bus.mem_req && ack_k < 0) begin
                memseen = 1'b1;
                chk("mem_addr", 32'(bus.mem_addr), 32'(addr));
                chk("mem_we", 32'(bus.mem_we), 32'(we));
                if (we) chk("mem_wdata", 32'(bus.mem_wdata), 32'(wdata));
                if (seen == delay) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = phys_mem[bus.mem_addr];
                    if (bus.mem_we) phys_mem[bus.mem_addr] = bus.mem_wdata;
                    ack_k = k;
                end
                seen++;
            end
            @(negedge clk);
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = DATAWIDTH'($urandom);
            k++;
        end
        if (!got) chk("resp_timeout", 32'd0, 32'd1);
        chk("rvalid_one_cycle", 32'(bus.cpu_rvalid), 32'd0);
        chk("ready_after_resp", 32'(bus.cpu_ready), 32'd1);

        if (we) begin
            ref_mem[addr] = wdata;
            if (exp_hit) m_data[i] = wdata;
        end else begin
            if (exp_hit) begin
                m_hits++;
            end else begin
                m_misses++;
                m_valid[i] = 1'b1;
                m_tag[i]   = t;
                m_data[i]  = ref_mem[addr];
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.tag_rdata = '0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        for (int w = 0; w < WORDS; w++) begin
            ref_mem[w]  = DATAWIDTH'($urandom);
            phys_mem[w] = ref_mem[w];
        end
        ref_mem[5'h13]  = 8'hA5;
        phys_mem[5'h13] = 8'hA5;
        ref_mem[5'h0B]  = 8'h5E;
        phys_mem[5'h0B] = 8'h5E;
        for (int l = 0; l < LINES; l++) begin
            m_valid[l] = 1'b0;
            m_tag[l]   = '0;
            m_data[l]  = '0;
            tag_ram[l] = TW'($urandom);
        end

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_cpu_ready", 32'(bus.cpu_ready), 32'd1);
        chk("rst_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
        chk("rst_cpu_rdata", 32'(bus.cpu_rdata), 32'd0);
        chk("rst_cpu_hit", 32'(bus.cpu_hit), 32'd0);
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_tag_read", 32'(bus.tag_read), 32'd0);
        chk("rst_tag_write", 32'(bus.tag_write), 32'd0);
        rst_n = 1'b1;

        // Directed: cold miss, hit, store hit, conflict miss, re-miss
        do_op(1'b0, 5'h13, 8'h00);
        chk("cold_fill_tag", 32'(tag_ram[3]), 32'd2);
        do_op(1'b0, 5'h13, 8'h00);
        do_op(1'b1, 5'h13, 8'h3C);
        chk("store_through", 32'(phys_mem[5'h13]), 32'h3C);
        do_op(1'b0, 5'h13, 8'h00);
        do_op(1'b0, 5'h0B, 8'h00);
        chk("conflict_fill_tag", 32'(tag_ram[3]), 32'd1);
        do_op(1'b0, 5'h13, 8'h00);
        do_op(1'b1, 5'h0B, 8'h77);

        // Reset while a refill is outstanding, then a stray ack
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 5'h0B;
        @(posedge clk);
        @(negedge clk);
        bus.cpu_req = 1'b0;
        for (int c = 0; c < 10 && !bus.mem_req; c++) begin
            if (bus.tag_read) bus.tag_rdata = tag_ram[bus.tag_index];
            @(negedge clk);
        end
        chk("abort_mem_req_seen", 32'(bus.mem_req), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_mem_req_drop", 32'(bus.mem_req), 32'd0);
        chk("abort_cpu_ready", 32'(bus.cpu_ready), 32'd1);
        for (int l = 0; l < LINES; l++) m_valid[l] = 1'b0;
        m_hits   = 0;
        m_misses = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 8'hEE;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("stray_ack_ready", 32'(bus.cpu_ready), 32'd1);
            chk("stray_ack_rvalid", 32'(bus.cpu_rvalid), 32'd0);
            chk("stray_ack_mem_req", 32'(bus.mem_req), 32'd0);
            @(negedge clk);
        end
        do_op(1'b0, 5'h13, 8'h00);
        do_op(1'b0, 5'h13, 8'h00);

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            do_op(($urandom_range(0, 3) == 0), MEMORYBITS'($urandom), DATAWIDTH'($urandom));
        end

`ifdef CACHE_STATS_EN
        chk("stats_hit_count", 32'(hit_count), 32'(m_hits));
        chk("stats_miss_count", 32'(miss_count), 32'(m_misses));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cache_ctrl.md
Name: cache_ctrl

Overview:
- Direct-mapped cache controller that consumes the tag store. It sits between the CPU load/store port and main memory.
- It drives the tag store's index, read and write strobes, compares the returned tag against the request, and holds the data array and valid bits.
- On a read miss it fetches from memory through a req/ack handshake and refills. Writes are write-through, no-write-allocate.

Parameters:
- INDEX, 3, index bits (address[INDEX-1:0])
- CACHESIZE, 8, lines; equals 2**INDEX
- MEMORYBITS, 5, full memory address width; tag width TW = MEMORYBITS-INDEX
- DATAWIDTH, 8, data word width

Ports:
- clk  in  1  clock, all logic on posedge
- rst_n  in  1  asynchronous active-low reset
- cpu_req  in  1  request strobe, sampled only while cpu_ready=1
- cpu_we  in  1  1=store, 0=load
- cpu_addr  in  MEMORYBITS  request address
- cpu_wdata  in  DATAWIDTH  store data
- cpu_ready  out  1  controller idle, accepting a request
- cpu_rvalid  out  1  one-cycle pulse: load data valid, or store complete
- cpu_rdata  out  DATAWIDTH  load data, valid with cpu_rvalid
- cpu_hit  out  1  hit flag, valid with cpu_rvalid
- tag_index  out  INDEX  tag store index
- tag_read  out  1  tag store read strobe
- tag_write  out  1  tag store write strobe
- tag_wdata  out  TW  tag to write
- tag_rdata  in  TW  tag store output, registered one cycle after tag_read
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  memory write
- mem_addr  out  MEMORYBITS  memory address
- mem_wdata  out  DATAWIDTH  memory write data
- mem_ack  in  1  one-cycle completion pulse
- mem_rdata  in  DATAWIDTH  read data, valid with mem_ack

Behaviour:
- Reset: state IDLE; valid[] all 0; all outputs 0 except cpu_ready=1. The data array is not cleared.
- States:
  - IDLE: cpu_ready=1. On cpu_req, latch addr, we and wdata, then go to LOOKUP.
  - LOOKUP: tag_read=1, tag_index=latched index, then go to COMPARE.
  - COMPARE: hit = valid[idx] && tag_rdata==addr tag.
    - load hit -> RESP
    - load miss -> MEMRD
    - store -> MEMWR; if hit, update data[idx] in this cycle.
  - MEMRD: mem_req=1, mem_we=0, mem_addr=latched addr. On mem_ack, capture mem_rdata and go to FILL.
  - FILL: tag_write=1, tag_wdata=latched tag, tag_index=idx; data[idx]<=captured data; valid[idx]<=1; then go to RESP.
  - MEMWR: mem_req=1, mem_we=1, mem_wdata=latched wdata. On mem_ack, go to RESP.
  - RESP: cpu_rvalid=1 for one cycle, then go to IDLE.
- Output registration: cpu_rdata, cpu_hit and cpu_rvalid are registered and asserted only in RESP.
- Load hit latency: request accepted at cycle N gives cpu_rvalid at N+3.
- Load miss latency: mem_ack at cycle M gives cpu_rvalid at M+2, with cpu_hit=0.
- Store response: cpu_hit reports the COMPARE result. A store miss does not allocate; valid and tag are unchanged.
- Handshake:
  - mem_req, mem_addr, mem_we and mem_wdata stay stable from state entry until the mem_ack cycle inclusive. mem_req drops the cycle after ack.
  - mem_ack outside MEMRD/MEMWR is ignored.
  - cpu_req outside IDLE is ignored; no queueing.
- tag_read and tag_write are never asserted together.
- Conflict (same index, different tag, valid): miss; FILL overwrites the line.
- Reset mid-operation, e.g. with mem_req high: outputs drop asynchronously, valid[] is cleared and the in-flight request is abandoned. A late mem_ack after reset is ignored.
- Address wrap: index = addr[INDEX-1:0], tag = addr[MEMORYBITS-1:INDEX]. No arithmetic on addresses.

Optional Feature:
- Macro CACHE_STATS_EN.
- Defined: adds outputs hit_count[15:0] and miss_count[15:0]. They increment in COMPARE for loads only, saturate at 16'hFFFF, and reset to 0.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package cache_pkg:
  - state enum (IDLE, LOOKUP, COMPARE, MEMRD, FILL, MEMWR, RESP)
  - default widths
  - TW derivation function
- One sub-module, cache_data_array: CACHESIZE x DATAWIDTH storage plus valid bits, with synchronous write, async valid clear on rst_n, and combinational read.
- The FSM stays in cache_ctrl.

Test Plan:
- Cold load of addr 5'b10_011 after reset -> miss; mem_req with mem_addr=0x13; ack with rdata=0xA5 -> FILL writes tag 2'b10 at index 3; cpu_rvalid with rdata=0xA5, hit=0.
- Repeat load of 0x13, tag RAM returning 2'b10 -> cpu_rvalid at N+3 with rdata=0xA5, hit=1, no mem_req.
- Store 0x13 with wdata=0x3C on the hit line -> data updated; mem_req we=1 wdata=0x3C; after ack, a load of 0x13 hits with 0x3C.
- Load 0x0B (index 3, tag 2'b01) after the above -> conflict miss; refill writes tag 01; a subsequent load of 0x13 misses.
- rst_n low while mem_req=1 -> mem_req=0 immediately, cpu_ready=1, stray mem_ack ignored; next load of 0x13 misses.
- With CACHE_STATS_EN: one miss then 3 hits -> miss_count=1, hit_count=3; counter preloaded near 0xFFFF saturates.
